// File: rtl/fp_stft_pkg.sv
// Shared constants, state encoding and small float helpers for the 4-point
// inverse-FFT serializer.
package fp_stft_pkg;

    localparam int F        = 4;
    localparam int FP_WIDTH = 32;
    localparam int N_OPS    = 2 * F;

    localparam logic [FP_WIDTH-1:0] QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]          SCALE_EXP = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    // Result slot holding y[n]: ops 4..7 produce y0, y2, y1, y3 in that order.
    function automatic logic [2:0] sample_slot(input logic [1:0] n);
        logic [2:0] slot;
        case (n)
            2'd0:    slot = 3'd4;
            2'd1:    slot = 3'd6;
            2'd2:    slot = 3'd5;
            default: slot = 3'd7;
        endcase
        return slot;
    endfunction

    // Multiply by 1/4 through the exponent; anything that would go denormal flushes.
    function automatic logic [FP_WIDTH-1:0] fp_scale4(input logic [FP_WIDTH-1:0] v);
        logic [FP_WIDTH-1:0] r;
        if (v[30:23] == 8'hFF)
            r = v;
        else if (v[30:23] <= SCALE_EXP)
            r = {v[31], 31'd0};
        else
            r = {v[31], v[30:23] - SCALE_EXP, v[22:0]};
        return r;
    endfunction

endpackage

// File: rtl/fp_addsub32.sv
// Combinational single-precision add/subtract, round-to-nearest-even,
// denormals flushed to signed zero on input and output.
module fp_addsub32
    import fp_stft_pkg::*;
(
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    input  logic                sub,
    output logic [FP_WIDTH-1:0] y
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (v[i])
                found = 1'b1;
            else if (!found)
                n = n + 5'd1;
        end
        return n;
    endfunction

    logic              w_sa, w_sb;
    logic [7:0]        w_ea, w_eb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic              w_swap, w_s_big, w_eff_sub;
    logic [7:0]        w_e_big, w_e_small, w_d;
    logic [23:0]       w_m_big, w_m_small;
    logic [26:0]       w_big_ext, w_small_ext, w_small_al, w_lost;
    logic [27:0]       w_sum;
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_e_norm, w_e_rnd;
    logic              w_rnd_up;
    logic [24:0]       w_mant_r;
    logic [22:0]       w_frac;
    logic [31:0]       w_y_num;

    always_comb begin
        w_sa     = a[31];
        w_sb     = b[31] ^ sub;
        w_ea     = a[30:23];
        w_eb     = b[30:23];
        w_a_zero = (w_ea == 8'd0);
        w_b_zero = (w_eb == 8'd0);
        w_a_inf  = (w_ea == 8'hFF) && (a[22:0] == 23'd0);
        w_b_inf  = (w_eb == 8'hFF) && (b[22:0] == 23'd0);
        w_a_nan  = (w_ea == 8'hFF) && (a[22:0] != 23'd0);
        w_b_nan  = (w_eb == 8'hFF) && (b[22:0] != 23'd0);

        // Order operands by magnitude so the difference is never negative.
        w_swap      = (b[30:0] > a[30:0]);
        w_s_big     = w_swap ? w_sb : w_sa;
        w_e_big     = w_swap ? w_eb : w_ea;
        w_e_small   = w_swap ? w_ea : w_eb;
        w_m_big     = {1'b1, w_swap ? b[22:0] : a[22:0]};
        w_m_small   = {1'b1, w_swap ? a[22:0] : b[22:0]};
        w_eff_sub   = w_sa ^ w_sb;
        w_d         = w_e_big - w_e_small;
        w_big_ext   = {w_m_big, 3'b000};
        w_small_ext = {w_m_small, 3'b000};
        w_lost      = 27'd0;

        if (w_d >= 8'd27) begin
            w_small_al = 27'd1;
        end else begin
            w_lost     = w_small_ext & ((27'd1 << w_d) - 27'd1);
            w_small_al = (w_small_ext >> w_d) | {26'd0, |w_lost};
        end

        w_sum = w_eff_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_al})
                          : ({1'b0, w_big_ext} + {1'b0, w_small_al});
        w_lz  = lzc27(w_sum[26:0]);

        if (w_sum[27]) begin
            w_norm   = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_e_norm = $signed({2'b00, w_e_big}) + 10'sd1;
        end else begin
            w_norm   = w_sum[26:0] << w_lz;
            w_e_norm = $signed({2'b00, w_e_big}) - $signed({5'd0, w_lz});
        end

        w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_r = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
        if (w_mant_r[24]) begin
            w_e_rnd = w_e_norm + 10'sd1;
            w_frac  = w_mant_r[23:1];
        end else begin
            w_e_rnd = w_e_norm;
            w_frac  = w_mant_r[22:0];
        end

        if (w_sum == 28'd0)
            w_y_num = 32'd0;
        else if (w_e_rnd <= 10'sd0)
            w_y_num = {w_s_big, 31'd0};
        else if (w_e_rnd >= 10'sd255)
            w_y_num = {w_s_big, 8'hFF, 23'd0};
        else
            w_y_num = {w_s_big, w_e_rnd[7:0], w_frac};

        if (w_a_nan)
            y = a | 32'h0040_0000;
        else if (w_b_nan)
            y = b | 32'h0040_0000;
        else if (w_a_inf && w_b_inf)
            y = (w_sa == w_sb) ? {w_sa, 8'hFF, 23'd0} : QNAN;
        else if (w_a_inf)
            y = {w_sa, 8'hFF, 23'd0};
        else if (w_b_inf)
            y = {w_sb, 8'hFF, 23'd0};
        else if (w_a_zero && w_b_zero)
            y = {w_sa & w_sb, 31'd0};
        else if (w_a_zero)
            y = {w_sb, b[30:0]};
        else if (w_b_zero)
            y = a;
        else
            y = w_y_num;
    end

endmodule

// File: rtl/fp_ifft4_serializer.sv
// 4-point inverse FFT on single-precision bins, one complex add/sub per cycle,
// results streamed out one sample at a time with valid/ready handshaking.
module fp_ifft4_serializer #(
    parameter int F = fp_stft_pkg::F
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    output logic                             ready_out,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] re_X0,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] re_X1,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] re_X2,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] re_X3,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] im_X0,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] im_X1,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] im_X2,
    input  logic [fp_stft_pkg::FP_WIDTH-1:0] im_X3,
    output logic [fp_stft_pkg::FP_WIDTH-1:0] re_out,
    output logic [fp_stft_pkg::FP_WIDTH-1:0] im_out,
    output logic [1:0]                       sample_idx,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic                             last_out
);
    import fp_stft_pkg::*;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [1:0]          r_idx;
    logic                r_valid;
    logic                r_last;
    logic [FP_WIDTH-1:0] r_re_out, r_im_out;
    logic [FP_WIDTH-1:0] r_xre [F];
    logic [FP_WIDTH-1:0] r_xim [F];
    logic [FP_WIDTH-1:0] r_tre [N_OPS];
    logic [FP_WIDTH-1:0] r_tim [N_OPS];

    // Lane 0 carries the real parts, lane 1 the imaginary parts.
    logic [FP_WIDTH-1:0] w_a [2];
    logic [FP_WIDTH-1:0] w_b [2];
    logic [FP_WIDTH-1:0] w_y [2];
    logic                w_sub [2];
    logic [1:0]          w_next_idx;
    logic [2:0]          w_slot;
    logic [FP_WIDTH-1:0] w_scaled_re, w_scaled_im;

    always_comb begin
        w_a[0]   = r_xre[0];
        w_b[0]   = r_xre[2];
        w_a[1]   = r_xim[0];
        w_b[1]   = r_xim[2];
        w_sub[0] = 1'b0;
        w_sub[1] = 1'b0;
        case (r_op)
            3'd1: begin
                w_sub[0] = 1'b1;
                w_sub[1] = 1'b1;
            end
            3'd2, 3'd3: begin
                w_a[0]   = r_xre[1];
                w_b[0]   = r_xre[3];
                w_a[1]   = r_xim[1];
                w_b[1]   = r_xim[3];
                w_sub[0] = (r_op == 3'd3);
                w_sub[1] = (r_op == 3'd3);
            end
            3'd4, 3'd5: begin
                w_a[0]   = r_tre[0];
                w_b[0]   = r_tre[2];
                w_a[1]   = r_tim[0];
                w_b[1]   = r_tim[2];
                w_sub[0] = (r_op == 3'd5);
                w_sub[1] = (r_op == 3'd5);
            end
            3'd6, 3'd7: begin
                // B -/+ j*D: the real lane pairs with D.im, the imaginary lane with D.re.
                w_a[0]   = r_tre[1];
                w_b[0]   = r_tim[3];
                w_a[1]   = r_tim[1];
                w_b[1]   = r_tre[3];
                w_sub[0] = (r_op == 3'd6);
                w_sub[1] = (r_op == 3'd7);
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            fp_addsub32 u_addsub (
                .a   (w_a[gi]),
                .b   (w_b[gi]),
                .sub (w_sub[gi]),
                .y   (w_y[gi])
            );
        end
    endgenerate

    assign w_next_idx  = r_valid ? (r_idx + 2'd1) : r_idx;
    assign w_slot      = sample_slot(w_next_idx);
    assign w_scaled_re = fp_scale4(r_tre[w_slot]);
    assign w_scaled_im = fp_scale4(r_tim[w_slot]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'd0;
            r_idx    <= 2'd0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_re_out <= '0;
            r_im_out <= '0;
            for (int i = 0; i < F; i++) begin
                r_xre[i] <= '0;
                r_xim[i] <= '0;
            end
            for (int i = 0; i < N_OPS; i++) begin
                r_tre[i] <= '0;
                r_tim[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_xre[0] <= re_X0;
                        r_xre[1] <= re_X1;
                        r_xre[2] <= re_X2;
                        r_xre[3] <= re_X3;
                        r_xim[0] <= im_X0;
                        r_xim[1] <= im_X1;
                        r_xim[2] <= im_X2;
                        r_xim[3] <= im_X3;
                        r_op     <= 3'd0;
                        r_idx    <= 2'd0;
                        r_state  <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_tre[r_op] <= w_y[0];
                    r_tim[r_op] <= w_y[1];
                    r_op        <= r_op + 3'd1;
                    if (r_op == 3'd7)
                        r_state <= ST_OUT;
                end
                ST_OUT: begin
                    // The first OUT cycle only loads sample 0; afterwards each transfer advances.
                    if (!r_valid) begin
                        r_valid  <= 1'b1;
                        r_re_out <= w_scaled_re;
                        r_im_out <= w_scaled_im;
                        r_last   <= (w_next_idx == 2'd3);
                    end else if (ready_in) begin
                        if (r_idx == 2'd3) begin
                            r_state  <= ST_IDLE;
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_idx    <= 2'd0;
                            r_re_out <= '0;
                            r_im_out <= '0;
                        end else begin
                            r_idx    <= w_next_idx;
                            r_re_out <= w_scaled_re;
                            r_im_out <= w_scaled_im;
                            r_last   <= (w_next_idx == 2'd3);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_out  = (r_state == ST_IDLE);
    assign valid_out  = r_valid;
    assign last_out   = r_last;
    assign sample_idx = r_idx;
    assign re_out     = r_re_out;
    assign im_out     = r_im_out;

endmodule

// File: doc/fp_ifft4_serializer.md
FP_IFFT4_SERIALIZER -- requirements
Module: fp_ifft4_serializer

Interface
REQ-001 SHALL have parameter F, default 4, meaning transform size; only 4 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port valid_in, input, 1, meaning a frame of 4 bins is offered.
REQ-005 SHALL have port ready_out, input-side ready, output, 1, meaning a frame is accepted on valid_in & ready_out.
REQ-006 SHALL have ports re_X0..re_X3 and im_X0..im_X3, input, 32 each, IEEE-754 single-precision bins.
REQ-007 SHALL have ports re_out and im_out, output, 32 each, the time-domain sample.
REQ-008 SHALL have port sample_idx, output, 2, the index n of the presented sample.
REQ-009 SHALL have port valid_out, output, 1, meaning re_out/im_out/sample_idx are valid.
REQ-010 SHALL have port ready_in, input, 1; a sample transfers on valid_out & ready_in.
REQ-011 SHALL have port last_out, output, 1, high with valid_out when sample_idx==3.

Function
REQ-012 SHALL compute x[n] = (1/4)·sum_k X[k]·e^(+j2πkn/4) for n=0..3.
REQ-013 SHALL use states IDLE, COMPUTE and OUT; ready_out is high only in IDLE.
REQ-014 SHALL, in IDLE on valid_in & ready_out, register all 8 input words and enter COMPUTE with op counter at 0.
REQ-015 SHALL execute one complex add/sub per COMPUTE cycle (re lane and im lane in parallel), in the order:
  ops 0-3: A=X0+X2, B=X0-X2, C=X1+X3, D=X1-X3;
  ops 4-7: y0=A+C, y2=A-C, y1=(B.re-D.im, B.im+D.re), y3=(B.re+D.im, B.im-D.re).
REQ-016 SHALL enter OUT after op 7, so valid_out first rises 9 cycles after the accepting edge.
REQ-017 SHALL present y[n] scaled by 1/4, starting with sample_idx=0 and incrementing on each transfer.
REQ-018 SHALL hold re_out, im_out, sample_idx and last_out stable while valid_out & !ready_in.
REQ-019 SHALL return to IDLE on the transfer of sample 3, with ready_out high in the next cycle.
REQ-020 SHALL ignore valid_in outside IDLE; no frame is queued.
REQ-021 SHALL implement add/sub with round-to-nearest-even.
REQ-022 SHALL flush denormal inputs and results to signed zero.
REQ-023 SHALL propagate inf/NaN per IEEE-754; inf-inf SHALL give quiet NaN 0x7FC00000.
REQ-024 SHALL scale by 1/4 as an exponent decrement by 2; exponent ≤2 gives signed zero; exponent 255 passes unchanged.
REQ-025 SHALL drive re_out and im_out to 0 whenever valid_out is low.

Reset
REQ-026 SHALL, when rst is high at a clock edge, enter IDLE and clear the op counter, sample_idx and the intermediate registers.
REQ-027 SHALL drive ready_out=1 and valid_out=0, last_out=0, re_out=0, im_out=0 in the cycle after reset.
REQ-028 SHALL let reset abort any COMPUTE or OUT frame; partial output is discarded and no later sample is emitted.

Structure
REQ-029 SHALL place the constants F=4, FP_WIDTH=32, the state encoding, QNAN=0x7FC00000 and the scale-exponent offset 2 in a shared package fp_stft_pkg.
REQ-030 SHALL use exactly two instances of a combinational sub-module fp_addsub32 (a, b, sub → y), one for the re lane and one for the im lane, with operand muxing in the top.

Verification
REQ-031 SHALL cover: X0=1.0 (0x3F800000), others 0 → four samples re=0x3E800000 (0.25), im=0; last_out on n=3.
REQ-032 SHALL cover: all re_Xk=1.0, im=0 → x0 re=0x3F800000, x1..x3 = 0.
REQ-033 SHALL cover: only re_X1=1.0 → x0=(0.25,0), x1=(0,0x3E800000), x2=(0xBE800000,0), x3=(0,0xBE800000).
REQ-034 SHALL cover: ready_in low 3 cycles while sample_idx=1 → outputs held stable; ready_out stays low; second valid_in during the stall is ignored.
REQ-035 SHALL cover: rst pulsed while sample_idx=2 → next cycle valid_out=0, ready_out=1, re_out=0; a new frame then produces samples starting at sample_idx=0.
REQ-036 SHALL cover: re_X0=0x00800000, others 0 → all outputs +0 (scale underflow); and re_X0=+inf, re_X2=-inf → x0 re=0x7FC00000.
